// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with configurable data width,
// optional parity and one or two stop bits.
//
// Ports:
//   CLK        sole clock, rising edge
//   RST        synchronous active-high reset
//   RX_IN      asynchronous serial line, idle high
//   prescale   CLK cycles per bit (4 .. 2^PRESCALE_W-1)
//   PAR_EN     parity bit present after the data bits
//   PAR_TYPE   0 = even, 1 = odd parity
//   STOP2      1 = two stop bits
//   P_DATA     last good word, LSB received first
//   data_valid one-cycle pulse when P_DATA updates
//   PAR_ERR    one-cycle pulse on parity mismatch
//   STP_ERR    one-cycle pulse when any stop bit is sampled low
module uart_rx_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYPE,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone} state_e;

  state_e                 state_q, state_d;
  logic [PRESCALE_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic                   par_fail_q, par_fail_d;
  logic                   stp_fail_q, stp_fail_d;
  logic [2:0]             samp_q, samp_d;
  logic [PRESCALE_W-1:0]  presc_q, presc_d;
  logic                   par_en_q, par_en_d;
  logic                   par_type_q, par_type_d;
  logic                   stop2_q, stop2_d;
  logic [DATA_WIDTH-1:0]  p_data_q, p_data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   par_err_q, par_err_d;
  logic                   stp_err_q, stp_err_d;

  logic sync1_q, sync2_q, prev_q;

  logic                  falling;
  logic [PRESCALE_W-1:0] half;
  logic                  bit_end;
  logic [2:0]            samp_cur;
  logic                  vote;
  logic                  stp_fail_now;

  // Two-flop synchronizer plus previous-value flop for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign falling = prev_q & ~sync2_q;
  assign half    = presc_q >> 1;
  assign bit_end = (edge_cnt_q == presc_q - PRESCALE_W'(1));

  // Samples taken in the current cycle are merged in so the vote at the end
  // of a bit can include a sample that lands on the very last count.
  always_comb begin
    samp_cur    = samp_q;
    if (edge_cnt_q == half - PRESCALE_W'(1)) samp_cur[0] = sync2_q;
    if (edge_cnt_q == half)                  samp_cur[1] = sync2_q;
    if (edge_cnt_q == half + PRESCALE_W'(1)) samp_cur[2] = sync2_q;
  end

  assign vote = (samp_cur[0] & samp_cur[1]) | (samp_cur[0] & samp_cur[2]) |
                (samp_cur[1] & samp_cur[2]);
  assign stp_fail_now = stp_fail_q | ~vote;

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_fail_d   = par_fail_q;
    stp_fail_d   = stp_fail_q;
    samp_d       = samp_q;
    presc_d      = presc_q;
    par_en_d     = par_en_q;
    par_type_d   = par_type_q;
    stop2_d      = stop2_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    if (state_q inside {StStart, StData, StParity, StStop}) begin
      samp_d     = samp_cur;
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
    end

    unique case (state_q)
      StIdle: ;
      StStart: begin
        if (bit_end) begin
          // A start bit that votes high was a glitch.
          state_d   = vote ? StIdle : StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shreg_d = {vote, shreg_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          if (vote != ((^shreg_q) ^ par_type_q)) par_fail_d = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          stp_fail_d = stp_fail_now;
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = BitCntW'(1);
          end else begin
            // Outputs are registered here so they are high exactly in DONE.
            state_d      = StDone;
            par_err_d    = par_fail_q;
            stp_err_d    = stp_fail_now;
            data_valid_d = ~(par_fail_q | stp_fail_now);
            if (!(par_fail_q | stp_fail_now)) p_data_d = shreg_q;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if ((state_q == StIdle || state_q == StDone) && falling) begin
      state_d    = StStart;
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
      par_fail_d = 1'b0;
      stp_fail_d = 1'b0;
      samp_d     = '1;
      presc_d    = prescale;
      par_en_d   = PAR_EN;
      par_type_d = PAR_TYPE;
      stop2_d    = STOP2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_fail_q   <= 1'b0;
      stp_fail_q   <= 1'b0;
      samp_q       <= '1;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      stop2_q      <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_fail_q   <= par_fail_d;
      stp_fail_q   <= stp_fail_d;
      samp_q       <= samp_d;
      presc_q      <= presc_d;
      par_en_q     <= par_en_d;
      par_type_q   <= par_type_d;
      stop2_q      <= stop2_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: frame-level reference model with an event
// scoreboard of expected output pulses (cycle, flags, P_DATA).
module tb_uart_rx_param;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] prescale;
  logic          PAR_EN, PAR_TYPE, STOP2;
  logic [DW-1:0] P_DATA;
  logic          data_valid, PAR_ERR, STP_ERR;

  uart_rx_param #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYPE   (PAR_TYPE),
    .STOP2      (STOP2),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            cyc;
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] pd;
  } ev_t;

  ev_t           mon_q[$];
  ev_t           exp_q[$];
  ev_t           mon_e;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_pdata = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (data_valid === 1'b1 || PAR_ERR === 1'b1 || STP_ERR === 1'b1) begin
      mon_e.cyc = cyc;
      mon_e.dv  = data_valid;
      mon_e.pe  = PAR_ERR;
      mon_e.se  = STP_ERR;
      mon_e.pd  = P_DATA;
      mon_q.push_back(mon_e);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one frame bit-by-bit and records the outcome the receiver owes.
  task automatic send_frame(input logic [DW-1:0] data, input int p, input logic pen,
                            input logic ptype, input logic s2, input logic par_flip,
                            input logic [1:0] stop_vals, input int gap, input int mid_p);
    logic line [0:15];
    int   nb;
    int   fall;
    logic pbit, pfail, sfail;
    ev_t  e;
    line[0] = 1'b0;
    for (int i = 0; i < DW; i++) line[1+i] = data[i];
    nb   = 1 + DW;
    pbit = (^data) ^ ptype ^ par_flip;
    if (pen) begin
      line[nb] = pbit;
      nb++;
    end
    line[nb] = stop_vals[0];
    nb++;
    if (s2) begin
      line[nb] = stop_vals[1];
      nb++;
    end
    @(negedge CLK);
    prescale = PW'(p);
    PAR_EN   = pen;
    PAR_TYPE = ptype;
    STOP2    = s2;
    fall     = cyc;
    for (int t = 0; t < nb * p; t++) begin
      if (t > 0) @(negedge CLK);
      RX_IN = line[t / p];
      if (t == 5 && mid_p > 0) begin
        prescale = PW'(mid_p);
        PAR_EN   = ~PAR_EN;
        PAR_TYPE = ~PAR_TYPE;
        STOP2    = ~STOP2;
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
    pfail = pen && (pbit != ((^data) ^ ptype));
    sfail = !stop_vals[0] || (s2 && !stop_vals[1]);
    if (!pfail && !sfail) exp_pdata = data;
    e.cyc = fall + nb * p + 3;
    e.dv  = !pfail && !sfail;
    e.pe  = pfail;
    e.se  = sfail;
    e.pd  = exp_pdata;
    exp_q.push_back(e);
  endtask

  task automatic compare_events(input string tag);
    int n;
    repeat (8) @(negedge CLK);
    check({tag, ".count"}, mon_q.size(), exp_q.size());
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ".cycle"}, mon_q[i].cyc, exp_q[i].cyc);
      check({tag, ".dv"}, 32'(mon_q[i].dv), 32'(exp_q[i].dv));
      check({tag, ".par_err"}, 32'(mon_q[i].pe), 32'(exp_q[i].pe));
      check({tag, ".stp_err"}, 32'(mon_q[i].se), 32'(exp_q[i].se));
      check({tag, ".p_data"}, 32'(mon_q[i].pd), 32'(exp_q[i].pd));
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int   brk_fall;
    ev_t  be;
    logic pen, ptype, s2, flip;
    logic [1:0] sv;
    RST      = 1'b1;
    RX_IN    = 1'b1;
    prescale = PW'(8);
    PAR_EN   = 1'b0;
    PAR_TYPE = 1'b0;
    STOP2    = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst.p_data", 32'(P_DATA), 32'h0);
    check("rst.dv", 32'(data_valid), 32'h0);
    check("rst.par_err", 32'(PAR_ERR), 32'h0);
    check("rst.stp_err", 32'(STP_ERR), 32'h0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // Basic 8N1 frame; expected pulse 83 cycles after the falling edge.
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4, 0);
    compare_events("a5");

    // Odd parity: 0x03 needs parity bit 1; first send it wrong, then right.
    send_frame(8'h03, 8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 4, 0);
    send_frame(8'h03, 8, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 4, 0);
    compare_events("parity");

    // Two-cycle glitch, then a valid frame.
    @(negedge CLK);
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (30) @(negedge CLK);
    compare_events("glitch");
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4, 0);
    compare_events("after_glitch");

    // Second stop bit low, then a frame whose start edge lands in DONE.
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1, 0);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4, 0);
    compare_events("stop2_b2b");

    // Config inputs change mid-frame; next frame runs at 16.
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3, 16);
    send_frame(8'h69, 16, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3, 0);
    compare_events("presc_switch");

    // Reset in the middle of a frame.
    @(negedge CLK);
    prescale = PW'(8);
    RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (12) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    exp_pdata = '0;
    check("midrst.p_data", 32'(P_DATA), 32'h0);
    repeat (40) @(negedge CLK);
    compare_events("midrst");
    check("midrst.p_data_hold", 32'(P_DATA), 32'h0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4, 0);
    compare_events("after_rst");

    // Break: line low for 40 bit-times at prescale 4.
    @(negedge CLK);
    prescale = PW'(4);
    PAR_EN   = 1'b0;
    STOP2    = 1'b0;
    brk_fall = cyc;
    RX_IN    = 1'b0;
    be.cyc = brk_fall + 10 * 4 + 3;
    be.dv  = 1'b0;
    be.pe  = 1'b0;
    be.se  = 1'b1;
    be.pd  = exp_pdata;
    exp_q.push_back(be);
    repeat (160) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (10) @(negedge CLK);
    compare_events("break");
    send_frame(8'h42, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4, 0);
    compare_events("after_break");

    // Randomized frames.
    for (int k = 0; k < 30; k++) begin
      pen   = 1'($urandom_range(0, 1));
      ptype = 1'($urandom_range(0, 1));
      s2    = 1'($urandom_range(0, 1));
      flip  = ($urandom_range(0, 3) == 0);
      sv    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send_frame(DW'($urandom), int'($urandom_range(4, 20)), pen, ptype, s2, flip, sv,
                 int'($urandom_range(1, 6)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(4, 63)) : 0);
    end
    compare_events("random");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets data bits per frame; legal range 5..9.
REQ-002 Parameter PRESCALE_W, default 6, sets the width of prescale.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset; synchronous and active-high.
REQ-005 RX_IN  input  1  asynchronous serial line; idle high.
REQ-006 prescale  input  PRESCALE_W  oversampling ratio (CLK cycles per bit); legal values 4..2^PRESCALE_W-1.
REQ-007 PAR_EN  input  1  1 = parity bit present after the data bits.
REQ-008 PAR_TYPE  input  1  0 = even parity, 1 = odd parity.
REQ-009 STOP2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 P_DATA  output  DATA_WIDTH  last good received word, LSB received first.
REQ-011 data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-012 PAR_ERR  output  1  one-cycle pulse when a frame has a parity mismatch.
REQ-013 STP_ERR  output  1  one-cycle pulse when any stop bit is sampled low.

Function
REQ-014 RX_IN SHALL pass through a 2-flop synchronizer before use; a falling edge is sync output 0 with its previous value 1.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, DONE.
REQ-016 On a falling edge in IDLE or DONE, the FSM SHALL enter START with edge_cnt=0 and bit_cnt=0.
REQ-017 On entering START, prescale, PAR_EN, PAR_TYPE and STOP2 SHALL be latched; changes to these inputs mid-frame SHALL have no effect on that frame.
REQ-018 edge_cnt SHALL count 0..prescale-1 per bit; a bit ends in the cycle where edge_cnt==prescale-1, and edge_cnt then wraps to 0.
REQ-019 Each bit value SHALL be the 2-of-3 majority of the synced line at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1, using integer division.
REQ-020 START transitions: a voted 1 is a glitch and SHALL return to IDLE with no output pulse; a voted 0 SHALL enter DATA.
REQ-021 DATA SHALL shift DATA_WIDTH voted bits LSB-first into an internal shift register, then enter PARITY if PAR_EN=1, else STOP.
REQ-022 PARITY: expected bit = XOR of the data bits, inverted when PAR_TYPE=1; a mismatch SHALL set an internal par_fail flag.
REQ-023 STOP SHALL sample 1 or 2 stop bits per the latched STOP2; any voted 0 SHALL set an internal stp_fail flag, and the FSM SHALL enter DONE after the last stop bit.
REQ-024 DONE SHALL last exactly one cycle; the FSM then goes to IDLE, or to START if a falling edge is present in that cycle.
REQ-025 In DONE, if neither flag is set, P_DATA SHALL load the shift register and data_valid SHALL be 1.
REQ-026 In DONE, PAR_ERR=par_fail and STP_ERR=stp_fail; when either flag is set, P_DATA SHALL hold and data_valid SHALL stay 0.
REQ-027 data_valid, PAR_ERR and STP_ERR SHALL be registered and SHALL be high only in the DONE cycle.
REQ-028 Latency: data_valid SHALL be high in cycle F*prescale+3 after the cycle in which RX_IN falls, where F = 1+DATA_WIDTH+PAR_EN+1+STOP2.
REQ-029 Because the start condition is a falling edge, a line held low (break) SHALL produce at most one frame and never retrigger until the line returns high.

Reset
REQ-030 With RST=1 at a rising edge, the following SHALL take effect in that cycle:
 - state = IDLE
 - edge_cnt, bit_cnt, shift register, flags = 0
 - synchronizer flops and previous-value flop = 1
 - P_DATA = 0; data_valid, PAR_ERR, STP_ERR = 0
REQ-031 RST asserted mid-frame SHALL abort the frame with no output pulse; the first falling edge after release SHALL start a fresh frame.

Verification
REQ-032 prescale=8, DATA_WIDTH=8, PAR_EN=0, STOP2=0, frame 0xA5 -> data_valid pulse in cycle 83, P_DATA=0xA5, PAR_ERR=STP_ERR=0.
REQ-033 PAR_EN=1, PAR_TYPE=1, data 0x03 with parity bit 0 -> PAR_ERR single pulse, data_valid=0, P_DATA keeps its prior value; same frame with parity bit 1 -> P_DATA=0x03.
REQ-034 RX_IN low for 2 cycles only at prescale=8 -> no pulses, FSM returns to IDLE; a following valid 0x5A frame -> P_DATA=0x5A.
REQ-035 STOP2=1 with second stop bit 0 -> STP_ERR pulse only; then a back-to-back frame 0xFF whose start edge lands in the DONE cycle -> P_DATA=0xFF.
REQ-036 prescale switched 8->16 mid-frame -> the current frame decodes at 8, the next at 16; RST pulse mid-frame -> no pulses, outputs 0.
REQ-037 Line held low 40 bit-times at prescale=4 -> exactly one STP_ERR pulse, then silence until the line rises.
